register_file: RTL and testbench

- 3-read / 1-write register file: 8 entries x 16 bits.
- Feeds operand fetch in the datapath:
  - three independent combinational read ports, A/B/C;
  - one synchronous write port.
- One clock `clk`; reset `nRESET` is asynchronous and active-low.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 21 ++
 rtl/register_file.sv | 65 ++++++
 tb/tb_register_file.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants and word/address types for the register file
package regfile_pkg;

    localparam int REGFILE_DATA_W = 16;
    localparam int REGFILE_ADDR_W = 3;
    localparam int REGFILE_DEPTH  = 8;

    typedef logic [REGFILE_DATA_W-1:0] word_t;
    typedef logic [REGFILE_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: DEPTH:1 combinational read mux over the register array
//   entries - all DEPTH entries, packed, entry i at entries[i]
//   addr    - entry select
//   data    - contents of entries[addr], zero latency
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int DEPTH  = REGFILE_DEPTH
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] entries,
    input  logic [ADDR_W-1:0]            addr,
    output logic [DATA_W-1:0]            data
);

    always_comb begin
        data = entries[addr];
    end

endmodule

// File: rtl/register_file.sv
// register_file: 8x16 register file, three combinational read ports, one synchronous write port
//   clk          - rising-edge clock for all state
//   nRESET       - asynchronous active-low reset, clears every entry
//   write_enable - write write_data into write_addr at the rising edge
//   write_addr   - write target entry
//   write_data   - write value
//   read_addr_X  - entry select for port X (A/B/C)
//   read_data_X  - contents of entry read_addr_X, no write bypass
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int DEPTH  = REGFILE_DEPTH
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr_A,
    input  logic [ADDR_W-1:0] read_addr_B,
    input  logic [ADDR_W-1:0] read_addr_C,
    output logic [DATA_W-1:0] read_data_A,
    output logic [DATA_W-1:0] read_data_B,
    output logic [DATA_W-1:0] read_data_C
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (write_enable)
            mem_d[write_addr] = write_data;
    end

    // Reset assertion clears the array without a clock; release timing is
    // the responsibility of the upstream reset synchroniser.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET)
            mem_q <= '0;
        else
            mem_q <= mem_d;
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port_a (
        .entries (mem_q),
        .addr    (read_addr_A),
        .data    (read_data_A)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port_b (
        .entries (mem_q),
        .addr    (read_addr_B),
        .data    (read_data_B)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port_c (
        .entries (mem_q),
        .addr    (read_addr_C),
        .data    (read_data_C)
    );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized and directed checks of register_file against an array model
module tb_register_file;

    logic        clk;
    logic        nRESET;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic [2:0]  read_addr_A;
    logic [2:0]  read_addr_B;
    logic [2:0]  read_addr_C;
    logic [15:0] read_data_A;
    logic [15:0] read_data_B;
    logic [15:0] read_data_C;

    logic [15:0] model [8];
    int vectors;
    int miscompares;

    register_file dut (
        .clk          (clk),
        .nRESET       (nRESET),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr_A  (read_addr_A),
        .read_addr_B  (read_addr_B),
        .read_addr_C  (read_addr_C),
        .read_data_A  (read_data_A),
        .read_data_B  (read_data_B),
        .read_data_C  (read_data_C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (nRESET && write_enable)
            model[write_addr] = write_data;
        #1;
    endtask

    task automatic check_ports(input string tag);
        #1;
        chk({tag, "_A"}, read_data_A, model[read_addr_A]);
        chk({tag, "_B"}, read_data_B, model[read_addr_B]);
        chk({tag, "_C"}, read_data_C, model[read_addr_C]);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            read_addr_A = 3'(i);
            read_addr_B = 3'(i);
            read_addr_C = 3'(i);
            check_ports(tag);
        end
    endtask

    task automatic assert_reset();
        nRESET = 1'b0;
        for (int i = 0; i < 8; i++)
            model[i] = 16'h0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        write_enable = 1'b0;
        write_addr = '0;
        write_data = '0;
        read_addr_A = '0;
        read_addr_B = '0;
        read_addr_C = '0;
        assert_reset();
        #2;
        sweep("por");
        step();
        step();
        nRESET = 1'b1;

        // fill entry i with 1<<(2*i), first write on the first edge after release
        write_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            write_addr = 3'(i);
            write_data = 16'(1 << (2 * i));
            step();
        end
        write_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_addr_A = 3'(i);
            read_addr_B = 3'(i);
            read_addr_C = 3'(i);
            #1;
            chk("fill_A", read_data_A, 16'(1 << (2 * i)));
            chk("fill_B", read_data_B, 16'(1 << (2 * i)));
            chk("fill_C", read_data_C, 16'(1 << (2 * i)));
        end

        read_addr_A = 3'd0;
        read_addr_B = 3'd3;
        read_addr_C = 3'd7;
        #1;
        chk("indep_A", read_data_A, 16'd1);
        chk("indep_B", read_data_B, 16'd64);
        chk("indep_C", read_data_C, 16'd16384);

        write_enable = 1'b0;
        write_addr = 3'd2;
        write_data = 16'hBEEF;
        repeat (3) step();
        read_addr_A = 3'd2;
        #1;
        chk("wdis", read_data_A, 16'd16);

        read_addr_A = 3'd5;
        read_addr_B = 3'd4;
        read_addr_C = 3'd4;
        write_enable = 1'b1;
        write_addr = 3'd5;
        write_data = 16'h1234;
        #1;
        chk("rdw_pre_A", read_data_A, 16'd1024);
        step();
        write_enable = 1'b0;
        chk("rdw_post_A", read_data_A, 16'h1234);
        chk("rdw_post_B", read_data_B, 16'd256);
        chk("rdw_post_C", read_data_C, 16'd256);

        for (int n = 0; n < 300; n++) begin
            write_enable = 1'($urandom_range(0, 1));
            write_addr = 3'($urandom);
            write_data = 16'($urandom);
            read_addr_A = 3'($urandom);
            read_addr_B = ($urandom_range(0, 3) == 0) ? read_addr_A : 3'($urandom);
            read_addr_C = ($urandom_range(0, 3) == 0) ? read_addr_A : 3'($urandom);
            check_ports("rnd_pre");
            step();
            check_ports("rnd_post");
        end
        write_enable = 1'b0;

        // mid-cycle reset with populated entries clears immediately
        #2;
        assert_reset();
        sweep("midrst");

        // write attempted while reset is held is ignored
        write_enable = 1'b1;
        write_addr = 3'd1;
        write_data = 16'hFFFF;
        step();
        step();
        write_enable = 1'b0;
        nRESET = 1'b1;
        read_addr_A = 3'd1;
        #1;
        chk("rst_vs_wr", read_data_A, 16'h0);

        write_enable = 1'b1;
        write_addr = 3'd3;
        write_data = 16'hA5C3;
        step();
        write_enable = 1'b0;
        read_addr_B = 3'd3;
        #1;
        chk("first_wr", read_data_B, 16'hA5C3);
        sweep("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
